wb_arbiter: RTL and testbench

//   Writeback arbiter directly upstream of the register file write port.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 59 +++++
 rtl/wb_arbiter.sv | 136 +++++++++++++
 tb/tb_wb_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: register-address width, the buffered
// result entry and the per-cycle grant source.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WB_XLEN    = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [WB_XLEN-1:0]    data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_MEM,
    SRC_FIFO,
    SRC_BYPASS
  } wb_src_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; head is read combinationally so a pop
// grant can present the entry in the same cycle.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         srst,
  input  logic                         push,
  input  logic                         pop,
  input  wb_entry_t                    din,
  output wb_entry_t                    dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers are power-of-two wide, so natural overflow gives the wrap.
  always_ff @(posedge clk) begin
    if (srst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: loads win, ALU results queue in wb_fifo, a starvation limiter
// forces the FIFO head out. Define WB_STATS_EN to add the write/starve counters.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN       = WB_XLEN,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_STARVE = 3
) (
  input  logic                              clock,
  input  logic                              RESET,
  input  logic                              alu_valid,
  input  logic [REG_ADDR_W-1:0]             alu_rd,
  input  logic [XLEN-1:0]                   alu_data,
  output logic                              alu_ready,
  input  logic                              mem_valid,
  input  logic [REG_ADDR_W-1:0]             mem_rd,
  input  logic [XLEN-1:0]                   mem_data,
  output logic                              mem_ready,
  output logic                              wr_en,
  output logic [REG_ADDR_W-1:0]             wr_select,
  output logic [XLEN-1:0]                   wr_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
`ifdef WB_STATS_EN
  ,
  output logic [31:0]                       stat_mem_wr,
  output logic [31:0]                       stat_alu_wr,
  output logic [31:0]                       stat_starve
`endif
);

  localparam int ST_W = $clog2(MAX_STARVE+1);
  localparam logic [ST_W-1:0] STARVE_LIMIT = ST_W'(MAX_STARVE);

  wb_entry_t        head;
  wb_entry_t        grant;
  wb_src_t          src;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             force_alu_reg;
  logic             force_alu_next;
  logic [ST_W-1:0]  starve_cnt_reg;
  logic [ST_W-1:0]  starve_cnt_next;

  assign mem_ready = !RESET && !force_alu_reg;
  assign alu_ready = !RESET && !fifo_full;

  always_comb begin
    src = SRC_NONE;
    if (RESET)                             src = SRC_NONE;
    else if (force_alu_reg && !fifo_empty) src = SRC_FIFO;
    else if (mem_valid && mem_ready)       src = SRC_MEM;
    else if (!fifo_empty)                  src = SRC_FIFO;
    else if (alu_valid)                    src = SRC_BYPASS;
  end

  // A bypassed result never enters the FIFO; every other accepted ALU result does.
  assign push = alu_valid && alu_ready && (src != SRC_BYPASS);
  assign pop  = (src == SRC_FIFO);

  always_comb begin
    case (src)
      SRC_MEM:    grant = '{rd: mem_rd, data: mem_data};
      SRC_FIFO:   grant = head;
      SRC_BYPASS: grant = '{rd: alu_rd, data: alu_data};
      default:    grant = '0;
    endcase
  end

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    force_alu_next  = 1'b0;
    if (src == SRC_MEM && !fifo_empty) begin
      starve_cnt_next = starve_cnt_reg + 1'b1;
      force_alu_next  = (starve_cnt_next == STARVE_LIMIT);
    end else if (src == SRC_FIFO || fifo_empty) begin
      starve_cnt_next = '0;
    end
  end

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clock),
    .srst  (RESET),
    .push  (push),
    .pop   (pop),
    .din   ('{rd: alu_rd, data: alu_data}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (RESET) begin
      wr_en          <= 1'b0;
      wr_select      <= '0;
      wr_data        <= '0;
      starve_cnt_reg <= '0;
      force_alu_reg  <= 1'b0;
    end else begin
      // rd==0 entries are consumed with the write suppressed; address/data still follow.
      wr_en          <= (src != SRC_NONE) && (grant.rd != '0);
      if (src != SRC_NONE) begin
        wr_select <= grant.rd;
        wr_data   <= grant.data;
      end
      starve_cnt_reg <= starve_cnt_next;
      force_alu_reg  <= force_alu_next;
    end
  end

`ifdef WB_STATS_EN
  always_ff @(posedge clock) begin
    if (RESET) begin
      stat_mem_wr <= '0;
      stat_alu_wr <= '0;
      stat_starve <= '0;
    end else begin
      if (src == SRC_MEM && grant.rd != '0) begin
        stat_mem_wr <= stat_mem_wr + 32'd1;
      end
      if ((src == SRC_FIFO || src == SRC_BYPASS) && grant.rd != '0) begin
        stat_alu_wr <= stat_alu_wr + 32'd1;
      end
      if (force_alu_reg) begin
        stat_starve <= stat_starve + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: accepted results are queued per source and
// matched against register-file writes; timing points are checked directly.
module tb_wb_arbiter;
  import wb_pkg::*;

  logic        clock = 1'b0;
  logic        RESET;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        wr_en;
  logic [4:0]  wr_select;
  logic [31:0] wr_data;
  logic [2:0]  fifo_count;
`ifdef WB_STATS_EN
  logic [31:0] stat_mem_wr;
  logic [31:0] stat_alu_wr;
  logic [31:0] stat_starve;
`endif

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t mem_q[$];
  exp_t alu_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  wb_arbiter dut (
    .clock      (clock),
    .RESET      (RESET),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .mem_valid  (mem_valid),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .wr_en      (wr_en),
    .wr_select  (wr_select),
    .wr_data    (wr_data),
    .fifo_count (fifo_count)
`ifdef WB_STATS_EN
    ,
    .stat_mem_wr (stat_mem_wr),
    .stat_alu_wr (stat_alu_wr),
    .stat_starve (stat_starve)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus; results accepted at this edge are queued as expectations.
  task automatic drive(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       output logic m_acc, output logic a_acc);
    exp_t e;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    m_acc = mv && mem_ready;
    a_acc = av && alu_ready;
    if (m_acc && mrd != 5'd0) begin e.rd = mrd; e.data = md; mem_q.push_back(e); end
    if (a_acc && ard != 5'd0) begin e.rd = ard; e.data = ad; alu_q.push_back(e); end
    @(posedge clock); #1;
    mem_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    logic m, a;
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, m, a);
  endtask

  // Every write must match the head of the queue of the source that produced it.
  always @(negedge clock) begin
    exp_t e;
    if (wr_en) begin
      $display("[%0t] write r%0d <= 0x%08h", $time, wr_select, wr_data);
      if (mem_q.size() > 0 && mem_q[0].rd == wr_select) begin
        e = mem_q.pop_front();
        check_eq("wr_mem", {27'd0, wr_select, wr_data}, {27'd0, e.rd, e.data});
      end else if (alu_q.size() > 0) begin
        e = alu_q.pop_front();
        check_eq("wr_alu", {27'd0, wr_select, wr_data}, {27'd0, e.rd, e.data});
      end else begin
        check_eq("wr_unexpected", wr_en, 1'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic m, a;
    int   a_sent;
    logic exp_mr;

    RESET = 1'b1;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_wr_en", wr_en, 1'b0);
    check_eq("rst_wr_select", wr_select, 5'd0);
    check_eq("rst_wr_data", wr_data, 32'd0);
    check_eq("rst_fifo_count", fifo_count, 3'd0);
    check_eq("rst_alu_ready", alu_ready, 1'b0);
    check_eq("rst_mem_ready", mem_ready, 1'b0);
    RESET = 1'b0;
    #1;
    check_eq("post_rst_alu_ready", alu_ready, 1'b1);
    check_eq("post_rst_mem_ready", mem_ready, 1'b1);

    // Bypass: empty FIFO, lone ALU result written one cycle later.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hA5, m, a);
    check_eq("t1_wr_en", wr_en, 1'b1);
    check_eq("t1_wr_select", wr_select, 5'd5);
    check_eq("t1_wr_data", wr_data, 32'hA5);
    check_eq("t1_fifo_count", fifo_count, 3'd0);

    // Simultaneous offer: load first, buffered ALU result next.
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, m, a);
    check_eq("t2_sel0", wr_select, 5'd3);
    check_eq("t2_data0", wr_data, 32'h11);
    check_eq("t2_count0", fifo_count, 3'd1);
    idle(1);
    check_eq("t2_sel1", wr_select, 5'd4);
    check_eq("t2_data1", wr_data, 32'h22);
    check_eq("t2_count1", fifo_count, 3'd0);

    // Loads held high with five ALU results: fill, back-pressure, forced drains every 4th cycle.
    a_sent = 0;
    for (int c = 0; c < 24; c++) begin
      exp_mr = !(c > 0 && (c % 4) == 0 && c <= 20);
      check_eq($sformatf("t3_mem_ready_c%0d", c), mem_ready, exp_mr);
      if (c == 4) begin
        check_eq("t3_alu_ready_full", alu_ready, 1'b0);
        check_eq("t3_count_full", fifo_count, 3'd4);
      end
      drive(1'b1, 5'(1 + (c % 8)), 32'h100 + 32'(c),
            a_sent < 5, 5'(16 + a_sent), 32'hA00 + 32'(a_sent), m, a);
      if (a) a_sent++;
    end
    check_eq("t3_alu_sent", a_sent, 5);
    idle(3);
    check_eq("t3_count_drained", fifo_count, 3'd0);

    // rd==0 through the FIFO: consumed, not written, address/data still follow.
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd0, 32'hFF, m, a);
    check_eq("t4_count1", fifo_count, 3'd1);
    idle(1);
    check_eq("t4_wr_en", wr_en, 1'b0);
    check_eq("t4_wr_select", wr_select, 5'd0);
    check_eq("t4_wr_data", wr_data, 32'hFF);
    check_eq("t4_count0", fifo_count, 3'd0);

    // Reset with three buffered entries discards them.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(1 + i), 32'h50 + 32'(i), 1'b1, 5'(20 + i), 32'hC0 + 32'(i), m, a);
    end
    check_eq("t5_count3", fifo_count, 3'd3);
    RESET = 1'b1;
    alu_q.delete();
    @(posedge clock); #1;
    check_eq("t5_count_rst", fifo_count, 3'd0);
    check_eq("t5_wr_en_rst", wr_en, 1'b0);
    RESET = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check_eq($sformatf("t5_no_stale_%0d", i), wr_en, 1'b0);
    end
    check_eq("t5_count_after", fifo_count, 3'd0);

    // Two loads and three ALU results (one to r0).
    drive(1'b1, 5'd1, 32'h1111, 1'b1, 5'd9, 32'h9999, m, a);
    drive(1'b1, 5'd2, 32'h2222, 1'b1, 5'd0, 32'h0BAD, m, a);
    idle(2);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h7777, m, a);
    idle(2);
    check_eq("t6_count", fifo_count, 3'd0);
`ifdef WB_STATS_EN
    check_eq("t6_stat_mem_wr", stat_mem_wr, 32'd2);
    check_eq("t6_stat_alu_wr", stat_alu_wr, 32'd2);
    check_eq("t6_stat_starve", stat_starve, 32'd0);
`endif

    idle(2);
    check_eq("mem_q_empty", mem_q.size(), 0);
    check_eq("alu_q_empty", alu_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
